// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op encodings (match funct[1:0] of mult/multu/div/divu)
//   - FSM state enumeration used by muldiv_unit
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the iterative mul/div datapath.
// Ports:
//   is_div  in   selects restoring-divide step (1) or shift-add step (0)
//   acc     in   2*DATA_W working register
//                  multiply: {partial product hi, remaining multiplier bits}
//                  divide:   {partial remainder, dividend bits / quotient bits}
//   opnd    in   multiplicand magnitude or divisor magnitude
//   acc_nxt out  working register after this iteration
module muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   acc_nxt
);

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_nxt;
  logic              q_bit;

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole register right; the carry
    // becomes the new MSB so nothing is lost.
    mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // try to subtract. The remainder is always below the divisor, so a
    // borrow shows up in the extra top bit of the difference.
    trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    diff  = trial - {1'b0, opnd};
    if (diff[DATA_W]) begin
      rem_nxt = trial[DATA_W-1:0];
      q_bit   = 1'b0;
    end else begin
      rem_nxt = diff[DATA_W-1:0];
      q_bit   = 1'b1;
    end

    if (is_div) acc_nxt = {rem_nxt, acc[DATA_W-2:0], q_bit};
    else        acc_nxt = {mul_sum, acc[DATA_W-1:1]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with its own HI/LO registers.
// Executes mult/multu/div/divu in DATA_W+1 busy cycles and serves mthi/mtlo.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start, op         begin an operation (op = funct[1:0])
//   a, b              operands; a is also the mthi/mtlo write data
//   mthi, mtlo        write a into HI / LO when not busy
//   mfhi, mflo        HI / LO read this cycle (only qualifies stall)
//   hi, lo            HI / LO registers
//   busy              operation in progress, including the DONE cycle
//   done              one-cycle pulse after HI/LO were written by an op
//   stall             busy and the core is touching HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic              mfhi,
  input  logic              mflo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              stall
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic                  b_zero_q, b_zero_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  done_q, done_d;

  logic [2*DATA_W-1:0]   iter_nxt;
  logic                  in_signed, in_sa, in_sb;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic                  res_signed, res_neg;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quot, rem, quot_fix, rem_fix;
  logic [DATA_W-1:0]     res_hi, res_lo;

  muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .is_div  (op_q[1]),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (iter_nxt)
  );

  always_comb begin
    // Operand capture: signed ops run on magnitudes, signs kept aside.
    in_signed = ~op[0];
    in_sa     = in_signed & a[DATA_W-1];
    in_sb     = in_signed & b[DATA_W-1];
    a_mag     = in_sa ? -a : a;
    b_mag     = in_sb ? -b : b;

    // Sign fix applied to the final iteration's output.
    res_signed = ~op_q[0];
    res_neg    = res_signed & (sign_a_q ^ sign_b_q);
    prod_fix   = res_neg ? -iter_nxt : iter_nxt;
    quot       = iter_nxt[DATA_W-1:0];
    rem        = iter_nxt[2*DATA_W-1:DATA_W];
    quot_fix   = res_neg ? -quot : quot;
    // A zero divisor leaves the whole dividend magnitude as remainder, so
    // re-applying a's sign reproduces the original a in HI.
    rem_fix    = (res_signed & sign_a_q) ? -rem : rem;
    if (op_q[1]) begin
      res_hi = rem_fix;
      res_lo = b_zero_q ? '1 : quot_fix;
    end else begin
      res_hi = prod_fix[2*DATA_W-1:DATA_W];
      res_lo = prod_fix[DATA_W-1:0];
    end

    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_RUN: begin
        acc_d = iter_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // start has priority; a simultaneous mthi/mtlo is dropped.
        if (!start) begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
    endcase

    // The DONE exit edge also samples start, so a held start reissues
    // exactly DATA_W+1 cycles after the previous one.
    if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d  = S_RUN;
      op_d     = op;
      sign_a_d = in_sa;
      sign_b_d = in_sb;
      b_zero_d = (b == '0);
      cnt_d    = '0;
      acc_d    = op[1] ? {{DATA_W{1'b0}}, a_mag} : {{DATA_W{1'b0}}, b_mag};
      opnd_d   = op[1] ? b_mag : a_mag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | mthi | mtlo | mfhi | mflo);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op    = 2'b00;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          mthi  = 1'b0;
  logic          mtlo  = 1'b0;
  logic          mfhi  = 1'b0;
  logic          mflo  = 1'b0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, stall;

  muldiv_unit #(.DATA_W(W)) dut (
    .clock (clock), .reset (reset), .start (start), .op (op),
    .a (a), .b (b), .mthi (mthi), .mtlo (mtlo), .mfhi (mfhi), .mflo (mflo),
    .hi (hi), .lo (lo), .busy (busy), .done (done), .stall (stall)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] sb_q[$];   // expected {hi, lo} per issued op

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs [0:6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clock) begin
    if (!reset && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: hi=%h lo=%h with no op outstanding", hi, lo);
      end else begin
        logic [2*W-1:0] exp;
        exp = sb_q.pop_front();
        $display("[TB] result hi=%h lo=%h (expected hi=%h lo=%h)", hi, lo, exp[2*W-1:W], exp[W-1:0]);
        check("hilo_result", 64'({hi, lo}), 64'(exp));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input bit push, input logic [W-1:0] eh, input logic [W-1:0] el);
    op = o; a = aa; b = bb; start = 1'b1;
    if (push) sb_q.push_back({eh, el});
  endtask

  // Runs ncyc cycles, dropping start after edge index 'hold', counting busy/done.
  task automatic watch(input int ncyc, input int hold, output int bn, output int dn);
    bn = 0; dn = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock); #1;
      if (i == hold) start = 1'b0;
      @(negedge clock);
      if (busy === 1'b1) bn++;
      if (done === 1'b1) dn++;
    end
  endtask

  int bn, dn;

  initial begin
    vecs[0] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[1] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[2] = '{2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    vecs[3] = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[4] = '{2'b00, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[5] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[6] = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_hi",    64'(hi),    64'(0));
    check("reset_lo",    64'(lo),    64'(0));
    check("reset_busy",  64'(busy),  64'(0));
    check("reset_done",  64'(done),  64'(0));
    check("reset_stall", 64'(stall), 64'(0));

    // Signed multiply, latency and done width.
    issue(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    watch(40, 0, bn, dn);
    check("mult_busy_cycles", 64'(bn), 64'(33));
    check("mult_done_width",  64'(dn), 64'(1));

    // Unsigned multiply, then start held so a second op issues at E33.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    sb_q.push_back({32'hFFFFFFFE, 32'h00000001});
    watch(72, 33, bn, dn);
    check("b2b_busy_cycles", 64'(bn), 64'(66));
    check("b2b_done_count",  64'(dn), 64'(2));

    // Directed divide/multiply vectors.
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo);
      watch(40, 0, bn, dn);
      check("vec_busy_cycles", 64'(bn), 64'(33));
    end

    // mthi/mfhi during RUN: stall, no write. hi still holds 2 from divu 100/7.
    issue(2'b00, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 mthi = 1'b1; a = 32'h1234;
    @(negedge clock);
    check("stall_mthi_run", 64'(stall), 64'(1));
    @(posedge clock); #1 mthi = 1'b0; mfhi = 1'b1;
    @(negedge clock);
    check("hi_held_run",     64'(hi),    64'(2));
    check("stall_mfhi_run",  64'(stall), 64'(1));
    mfhi = 1'b0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) @(negedge clock);
    check("idle_after_op", 64'(busy), 64'(0));
    mthi = 1'b1; mflo = 1'b1; a = 32'h1234;
    #1 check("stall_idle", 64'(stall), 64'(0));
    @(posedge clock); #1 mthi = 1'b0; mflo = 1'b0;
    @(negedge clock);
    check("mthi_idle_hi", 64'(hi), 64'(32'h1234));
    check("mthi_idle_lo", 64'(lo), 64'(6));

    // start + mtlo in IDLE: the op wins.
    issue(2'b01, 32'd9, 32'd4, 1'b1, 32'd0, 32'h24);
    mtlo = 1'b1;
    @(posedge clock); #1 start = 1'b0; mtlo = 1'b0;
    @(negedge clock);
    check("mtlo_dropped_lo", 64'(lo), 64'(6));
    watch(40, 0, bn, dn);
    check("start_mtlo_done", 64'(dn), 64'(1));

    // Reset mid-operation discards the op.
    issue(2'b00, 32'd7, 32'd9, 1'b0, 32'd0, 32'd0);
    @(posedge clock); #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_hi",   64'(hi),   64'(0));
    check("midreset_lo",   64'(lo),   64'(0));
    check("midreset_done", 64'(done), 64'(0));
    watch(40, 40, bn, dn);
    check("midreset_no_done", 64'(dn), 64'(0));

    issue(2'b00, 32'd7, 32'd9, 1'b1, 32'd0, 32'h3F);
    watch(40, 0, bn, dn);
    check("fresh_busy_cycles", 64'(bn), 64'(33));
    check("fresh_done",        64'(dn), 64'(1));

    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
